stage_wb: RTL and testbench
===========================

Name: stage_wb

Overview:
- Writeback stage directly downstream of the memory stage in the pipelined ARM core.
- Registers the memory stage's outputs (MEM/WB pipeline register) and selects load data or ALU result.
- Drives the register-file write port.
- Keeps a one-entry retired-result history so the hazard/forwarding unit can forward from the last two writers.

Parameters:
- DATA_W, 32, width of ALU result, load data and writeback value
- REG_W, 4, width of destination register index
- CNT_W, 32, width of each performance counter (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- freeze  in  1  memory stage stalled on cache/SRAM; MEM outputs not valid this cycle
- wbEnIn  in  1  writeback enable from memory stage (already gated by freeze upstream)
- memREnIn  in  1  instruction is a load
- aluResIn  in  DATA_W  ALU result / address from memory stage
- memIn  in  DATA_W  load data from memory stage
- destIn  in  REG_W  destination register
- wbEn  out  1  register-file write enable
- wbDest  out  REG_W  register-file write index
- wbValue  out  DATA_W  register-file write data
- histValid  out  1  previous retired writer valid
- histDest  out  REG_W  previous retired writer index
- histValue  out  DATA_W  previous retired writer data

Behaviour:
- Reset (rst=0, asynchronous):
  - all registered state cleared: wbEn=0, wbDest=0, wbValue=0, histValid=0, histDest=0, histValue=0
  - applies mid-operation; takes effect without waiting for a clock edge
- Pipeline register, captured every rising edge:
  - valid_q <= wbEnIn & ~freeze
  - dest_q <= destIn
  - ld_q <= memREnIn
  - alu_q <= aluResIn
  - mem_q <= memIn
- Writeback outputs are combinational from the register, one cycle latency from the MEM outputs:
  - wbEn = valid_q
  - wbDest = dest_q
  - wbValue = ld_q ? mem_q : alu_q
- Freeze handling:
  - never holds the register; a frozen cycle always inserts a bubble (valid_q=0)
  - the frozen instruction retires in the first cycle after freeze deasserts, exactly once
  - freeze=1 with wbEnIn=1 (upstream gating broken) still captures valid_q=0
- History register, updated only when valid_q=1:
  - histValid <= 1, histDest <= dest_q, histValue <= wbValue
  - bubbles leave history unchanged
- History semantics:
  - hist* always describes the most recent retired writer before the current WB occupant
  - wbDest == histDest with both valid is legal; the consumer prioritises wb* over hist*
- Load with wbEnIn=0 (store, or non-writing instruction): no register-file write, history untouched.
- No arithmetic on data; all widths pass through unchanged.

Optional Feature:
- Macro STAGE_WB_PERF_EN.
- Defined: adds outputs retiredCnt, loadCnt, bubbleCnt, each CNT_W bits, plus input perfClr (1 bit).
  - every rising edge: retiredCnt += valid_q; loadCnt += valid_q & ld_q; bubbleCnt += freeze
  - all counters wrap modulo 2^CNT_W
  - perfClr=1 zeroes all three on the next edge and takes priority over increment
  - reset zeroes all three
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W and REG_W constants
  - typedef wb_bundle_t {valid, dest, isLoad, alu, mem}, reused by the memory stage output bus
- One natural sub-module: wb_perf_counters, instantiated only under STAGE_WB_PERF_EN.

Test Plan:
- ALU op: wbEnIn=1, memREnIn=0, aluResIn=0x0000_0010, destIn=3 -> next cycle wbEn=1, wbDest=3, wbValue=0x10.
- Load: memREnIn=1, memIn=0xDEAD_BEEF, aluResIn=0x100, destIn=5 -> wbValue=0xDEADBEEF.
- Freeze: freeze=1 for 3 cycles with wbEnIn=1 -> wbEn=0 for 3 cycles; freeze drops -> wbEn=1 exactly one cycle; histValid unchanged during bubbles.
- History: retire r1=0x11, then r2=0x22 -> while r2 in WB, histDest=1, histValue=0x11.
- Async reset mid-stream: rst=0 between clock edges while wbEn=1 -> all outputs 0 immediately; first post-reset capture behaves normally.
- Perf (macro defined), CNT_W=4:
  - 17 retirements -> retiredCnt=1 (wrap)
  - perfClr=1 on the same edge as a retirement -> retiredCnt=0

Source files
------------

// File: rtl/stage_wb_pkg.sv
// stage_wb_pkg: shared writeback-stage constants and the MEM/WB bundle type.
//   DATA_W      : datapath width (ALU result, load data, writeback value)
//   REG_W       : register-index width
//   wb_bundle_t : memory-stage output bundle, also the MEM/WB register layout
package stage_wb_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    logic              isLoad;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
  } wb_bundle_t;
endpackage

// File: rtl/stage_wb_if.sv
// stage_wb_if: MEM->WB bus plus the register-file write port and history outputs.
//   master : memory stage / consumers (drive MEM outputs, observe wb*/hist*)
//   slave  : stage_wb (consume MEM outputs, drive wb*/hist*)
interface stage_wb_if
  import stage_wb_pkg::*;
#(
  parameter int DATA_W = stage_wb_pkg::DATA_W,
  parameter int REG_W  = stage_wb_pkg::REG_W
);
  logic              freeze;
  logic              wbEnIn;
  logic              memREnIn;
  logic [DATA_W-1:0] aluResIn;
  logic [DATA_W-1:0] memIn;
  logic [REG_W-1:0]  destIn;

  logic              wbEn;
  logic [REG_W-1:0]  wbDest;
  logic [DATA_W-1:0] wbValue;
  logic              histValid;
  logic [REG_W-1:0]  histDest;
  logic [DATA_W-1:0] histValue;

  modport master (
    output freeze, wbEnIn, memREnIn, aluResIn, memIn, destIn,
    input  wbEn, wbDest, wbValue, histValid, histDest, histValue
  );

  modport slave (
    input  freeze, wbEnIn, memREnIn, aluResIn, memIn, destIn,
    output wbEn, wbDest, wbValue, histValid, histDest, histValue
  );
endinterface

// File: rtl/stage_wb_perf_counters.sv
// wb_perf_counters: retired / load / bubble event counters for the WB stage.
// Only built with STAGE_WB_PERF_EN defined.
//   clk, rst_n    : clock, async active-low reset
//   clr           : synchronous clear, wins over increment
//   retire_inc    : a writer retires this cycle
//   load_inc      : the retiring writer is a load
//   bubble_inc    : memory stage frozen this cycle
//   retired_cnt, load_cnt, bubble_cnt : wrapping CNT_W-bit counters
`ifdef STAGE_WB_PERF_EN
module wb_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             retire_inc,
  input  logic             load_inc,
  input  logic             bubble_inc,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      load_cnt    <= '0;
      bubble_cnt  <= '0;
    end else if (clr) begin
      retired_cnt <= '0;
      load_cnt    <= '0;
      bubble_cnt  <= '0;
    end else begin
      retired_cnt <= retired_cnt + CNT_W'(retire_inc);
      load_cnt    <= load_cnt    + CNT_W'(load_inc);
      bubble_cnt  <= bubble_cnt  + CNT_W'(bubble_inc);
    end
  end
endmodule
`endif

// File: rtl/stage_wb.sv
// stage_wb: writeback stage. MEM/WB pipeline register, load/ALU select,
// register-file write port and a one-entry retired-writer history for forwarding.
//   clk  : rising-edge clock
//   rst  : async reset, active low
//   bus  : stage_wb_if.slave (MEM outputs in; wb*/hist* out)
// Optional (STAGE_WB_PERF_EN): perfClr in; retiredCnt, loadCnt, bubbleCnt out.
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int DATA_W = stage_wb_pkg::DATA_W,
  parameter int REG_W  = stage_wb_pkg::REG_W,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef STAGE_WB_PERF_EN
  input  logic             perfClr,
  output logic [CNT_W-1:0] retiredCnt,
  output logic [CNT_W-1:0] loadCnt,
  output logic [CNT_W-1:0] bubbleCnt,
`endif
  stage_wb_if.slave        bus
);
  wb_bundle_t        wb_q;
  logic [DATA_W-1:0] wb_value;
  logic              hist_vld_q;
  logic [REG_W-1:0]  hist_dest_q;
  logic [DATA_W-1:0] hist_val_q;

  // The register never holds: a frozen cycle always becomes a bubble, even if
  // upstream failed to gate wbEnIn, so the frozen instruction retires exactly
  // once when the memory stage re-presents it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else begin
      wb_q.valid  <= bus.wbEnIn & ~bus.freeze;
      wb_q.dest   <= bus.destIn;
      wb_q.isLoad <= bus.memREnIn;
      wb_q.alu    <= bus.aluResIn;
      wb_q.mem    <= bus.memIn;
    end
  end

  assign wb_value = wb_q.isLoad ? wb_q.mem : wb_q.alu;

  // History tracks the last writer that actually retired; bubbles skip it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_vld_q  <= 1'b0;
      hist_dest_q <= '0;
      hist_val_q  <= '0;
    end else if (wb_q.valid) begin
      hist_vld_q  <= 1'b1;
      hist_dest_q <= wb_q.dest;
      hist_val_q  <= wb_value;
    end
  end

  assign bus.wbEn      = wb_q.valid;
  assign bus.wbDest    = wb_q.dest;
  assign bus.wbValue   = wb_value;
  assign bus.histValid = hist_vld_q;
  assign bus.histDest  = hist_dest_q;
  assign bus.histValue = hist_val_q;

`ifdef STAGE_WB_PERF_EN
  wb_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst_n       (rst),
    .clr         (perfClr),
    .retire_inc  (wb_q.valid),
    .load_inc    (wb_q.valid & wb_q.isLoad),
    .bubble_inc  (bus.freeze),
    .retired_cnt (retiredCnt),
    .load_cnt    (loadCnt),
    .bubble_cnt  (bubbleCnt)
  );
`endif
endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: directed self-checking bench for stage_wb.
module tb_stage_wb;
  import stage_wb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stage_wb_if #(.DATA_W(32), .REG_W(4)) bus ();

`ifdef STAGE_WB_PERF_EN
  logic       perfClr;
  logic [3:0] retiredCnt, loadCnt, bubbleCnt;
  stage_wb #(.DATA_W(32), .REG_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .perfClr(perfClr), .retiredCnt(retiredCnt),
    .loadCnt(loadCnt), .bubbleCnt(bubbleCnt), .bus(bus.slave));
`else
  stage_wb #(.DATA_W(32), .REG_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fz, input logic we, input logic ld,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] dst);
    bus.freeze   = fz;
    bus.wbEnIn   = we;
    bus.memREnIn = ld;
    bus.aluResIn = alu;
    bus.memIn    = mem;
    bus.destIn   = dst;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
`ifdef STAGE_WB_PERF_EN
    perfClr = 1'b0;
`endif
    #12;
    chk("rst_wbEn",      bus.wbEn,      1'b0);
    chk("rst_wbDest",    bus.wbDest,    4'h0);
    chk("rst_wbValue",   bus.wbValue,   32'h0);
    chk("rst_histValid", bus.histValid, 1'b0);
    rst = 1'b1;

    // ALU op
    drive(0, 1, 0, 32'h0000_0010, 32'h0000_0055, 4'd3);
    step();
    chk("alu_wbEn",      bus.wbEn,      1'b1);
    chk("alu_wbDest",    bus.wbDest,    4'd3);
    chk("alu_wbValue",   bus.wbValue,   32'h10);
    chk("alu_histValid", bus.histValid, 1'b0);

    // Load
    drive(0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'd5);
    step();
    chk("ld_wbDest",    bus.wbDest,    4'd5);
    chk("ld_wbValue",   bus.wbValue,   32'hDEAD_BEEF);
    chk("ld_histValid", bus.histValid, 1'b1);
    chk("ld_histDest",  bus.histDest,  4'd3);
    chk("ld_histValue", bus.histValue, 32'h10);

    // Freeze three cycles with wbEnIn stuck high
    drive(1, 1, 0, 32'h0000_0077, 32'h0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz%0d_wbEn", i),      bus.wbEn,      1'b0);
      chk($sformatf("frz%0d_histDest", i),  bus.histDest,  4'd5);
      chk($sformatf("frz%0d_histValue", i), bus.histValue, 32'hDEAD_BEEF);
    end
    bus.freeze = 1'b0;
    step();
    chk("unfrz_wbEn",    bus.wbEn,    1'b1);
    chk("unfrz_wbDest",  bus.wbDest,  4'd7);
    chk("unfrz_wbValue", bus.wbValue, 32'h77);
    bus.wbEnIn = 1'b0;
    step();
    chk("unfrz_once_wbEn", bus.wbEn,     1'b0);
    chk("unfrz_histDest",  bus.histDest, 4'd7);

    // History across back-to-back writers
    drive(0, 1, 0, 32'h11, 32'h0, 4'd1);
    step();
    drive(0, 1, 0, 32'h22, 32'h0, 4'd2);
    step();
    chk("hist_wbDest",    bus.wbDest,    4'd2);
    chk("hist_wbValue",   bus.wbValue,   32'h22);
    chk("hist_histDest",  bus.histDest,  4'd1);
    chk("hist_histValue", bus.histValue, 32'h11);

    // Store (load flagged, no write): no retire, history untouched after r2
    drive(0, 0, 1, 32'h200, 32'hCAFE_F00D, 4'd9);
    step();
    chk("st_wbEn",     bus.wbEn,     1'b0);
    chk("st_histDest", bus.histDest, 4'd2);
    step();
    chk("st2_histDest",  bus.histDest,  4'd2);
    chk("st2_histValue", bus.histValue, 32'h22);

    // Async reset mid-stream
    drive(0, 1, 0, 32'hABC, 32'h0, 4'd4);
    step();
    chk("pre_rst_wbEn", bus.wbEn, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_wbEn",      bus.wbEn,      1'b0);
    chk("arst_wbDest",    bus.wbDest,    4'h0);
    chk("arst_wbValue",   bus.wbValue,   32'h0);
    chk("arst_histValid", bus.histValid, 1'b0);
    chk("arst_histDest",  bus.histDest,  4'h0);
    chk("arst_histValue", bus.histValue, 32'h0);
    rst = 1'b1;
    step();
    chk("post_rst_wbEn",      bus.wbEn,      1'b1);
    chk("post_rst_wbDest",    bus.wbDest,    4'd4);
    chk("post_rst_wbValue",   bus.wbValue,   32'hABC);
    chk("post_rst_histValid", bus.histValid, 1'b0);

`ifdef STAGE_WB_PERF_EN
    // valid_q already 1; clear, then 17 retiring edges wraps a 4-bit counter to 1
    perfClr = 1'b1;
    step();
    perfClr = 1'b0;
    chk("perf_clr_retired", retiredCnt, 4'd0);
    for (int i = 0; i < 17; i++) step();
    chk("perf_wrap_retired", retiredCnt, 4'd1);
    chk("perf_loads",        loadCnt,    4'd0);
    chk("perf_bubbles",      bubbleCnt,  4'd0);
    perfClr = 1'b1;
    step();
    perfClr = 1'b0;
    chk("perf_clr_prio", retiredCnt, 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
